reg_writeback: RTL
==================

// Module: reg_writeback
// PURPOSE
//  Write side of the 8x32 register file. Captures the destination register and result of the current instruction.
//  Waits for load data where needed, then drives wa/wd/we for exactly one cycle in phase w.
//  Sits between the x/m datapath and the register file in the 5-phase (f,r,x,m,w) multicycle core.
// PARAMETERS
//  N           32   data width (wd, alu_res, mem_rdata, pc_link)
//  AW          3    register address width (8 registers)
//  MEM_TIMEOUT 15   max phase-m cycles to wait for mem_valid before abort (1..2^TW-1)
//  TW          4    width of the wait counter
// PORTS
//  clk        in   1    clock, all state on posedge
//  n_rst      in   1    asynchronous active-low reset
//  phase      in   5    one-hot phase: bit0 f, bit1 r, bit2 x, bit3 m, bit4 w
//  wb_en      in   1    instruction writes a register (sampled in x)
//  wb_sel     in   2    result source: 0 ALU, 1 MEM, 2 LINK, 3 reserved (treated as ALU)
//  dst        in   AW   destination register (sampled in x)
//  alu_res    in   N    ALU result (sampled in x)
//  pc_link    in   N    return address pc+4 (sampled in x)
//  mem_rdata  in   N    load data, valid when mem_valid=1 in phase m
//  mem_valid  in   1    load data handshake
//  stall      out  1    hold sequencer in m: waiting for mem_valid
//  wa         out  AW   register file write address
//  wd         out  N    register file write data
//  we         out  1    register file write enable
//  err        out  2    sticky: [0] load timeout, [1] capture overrun
// BEHAVIOUR
//  - Reset (n_rst=0, any time, mid-wait included): state IDLE; held addr/data/count=0; err=0.
//    Outputs then: stall=0, we=0, wa=0, wd=0.
//  - States: IDLE, PEND (ALU/LINK captured), WMEM (awaiting load), READY, no others.
//  - phase[x] at posedge:
//    - wb_en=0 -> IDLE.
//    - wb_sel=MEM -> WMEM, count cleared.
//    - otherwise -> READY. Held data is alu_res (sel 0/3) or pc_link (sel 2), addr=dst.
//  - Capture while READY/WMEM/PEND (previous write never retired): new capture wins; err[1] set.
//  - WMEM, phase[m]:
//    - mem_valid=1 -> latch mem_rdata, go READY; stall=0 that cycle.
//    - mem_valid=0 -> stall=1 (combinational); count+1.
//    - count reaching MEM_TIMEOUT with no data -> IDLE, err[0] set, write dropped; stall=0 from next cycle.
//  - stall is asserted only in state WMEM during phase[m]; never in any other phase or state.
//  - READY, phase[w]: we=1, wa=held addr, wd=held data (combinational from held regs).
//    Register file commits at that posedge; state -> IDLE. Write latency = 1 cycle into w.
//  - WMEM reaching phase[w] (sequencer ignored stall): no write; -> IDLE; err[0] set.
//  - wa/wd always show held regs; only we qualifies them.
//  - phase all-zero or not one-hot: no transition, we=0, stall=0.
//  - err bits clear only on reset.
// CONFIGURATION
//  R0_ZERO_EN defined: writes with held addr==0 are suppressed (we stays 0).
//    State still retires to IDLE; r0 reads as constant zero.
//  R0_ZERO_EN undefined: r0 is an ordinary register, written like any other.
// STRUCTURE
//  Shared package/header: phase bit indices (F=0,R=1,X=2,M=3,W=4).
//    Also WB_ALU/WB_MEM/WB_LINK encodings and state encodings, shared with sequencer and decoder.
//  Sub-module wb_wait_counter: TW-bit counter with clear, enable, terminal-count flag at MEM_TIMEOUT.
//  Remainder of the block: FSM, holding registers, output logic.
// TESTING
//  1 ALU: x with wb_en=1, sel=0, dst=3, alu_res=0x1234_5678 -> phase w: we=1, wa=3, wd=0x1234_5678.
//    Register file rf[3] reads back that value.
//  2 Load with delay: sel=1, dst=5; mem_valid low 3 m-cycles then high with 0xDEAD_BEEF.
//    -> stall=1 for 3 cycles, 0 on 4th; w writes rf[5]=0xDEAD_BEEF.
//  3 Timeout: sel=1, mem_valid never asserted -> stall for 15 cycles, then err[0]=1.
//    Next w has we=0; rf unchanged.
//  4 Link and r0: sel=2, dst=0, pc_link=0x40 -> with R0_ZERO_EN we=0 in w.
//    Without R0_ZERO_EN, rf[0]=0x40.
//  5 Reset mid-wait: n_rst pulsed low during WMEM stall -> stall=0, we=0, err=0 immediately.
//    No write after release.
//  6 Overrun: two x captures without intervening w -> err[1]=1; the w that follows writes the second capture only.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared encodings for the writeback stage: phase bit indices, result-source selects, FSM states.
// Used by the sequencer and decoder as well as reg_writeback.
package reg_writeback_pkg;

    localparam int unsigned PH_F = 0;
    localparam int unsigned PH_R = 1;
    localparam int unsigned PH_X = 2;
    localparam int unsigned PH_M = 3;
    localparam int unsigned PH_W = 4;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [1:0] WB_RSV  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_WMEM,
        ST_READY
    } wb_state_e;

endpackage

// File: rtl/reg_writeback_wait_counter.sv
// Load-wait counter for the writeback stage: clear, enable, and a flag that is high when the
// next increment lands on MEM_TIMEOUT.
module wb_wait_counter #(
    parameter int unsigned TW          = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/reg_writeback.sv
// Write side of the 8x32 register file: captures dst/result in x, waits for load data in m,
// drives wa/wd/we in w. Define R0_ZERO_EN to suppress writes to register 0.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned N           = 32,
    parameter int unsigned AW          = 3,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TW          = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [4:0]    phase,
    input  logic          wb_en,
    input  logic [1:0]    wb_sel,
    input  logic [AW-1:0] dst,
    input  logic [N-1:0]  alu_res,
    input  logic [N-1:0]  pc_link,
    input  logic [N-1:0]  mem_rdata,
    input  logic          mem_valid,
    output logic          stall,
    output logic [AW-1:0] wa,
    output logic [N-1:0]  wd,
    output logic          we,
    output logic [1:0]    err
);

    wb_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [N-1:0]  data_q, data_d;
    logic [1:0]    err_q, err_d;
    logic          cnt_clr, cnt_en, cnt_tc;
    logic          phase_ok;
    logic          wr_ok;

    assign phase_ok = $onehot(phase);

    wb_wait_counter #(
        .TW          (TW),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait (
        .clk   (clk),
        .n_rst (n_rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (phase_ok) begin
            if (phase[PH_X]) begin
                if (wb_en) begin
                    // A capture over an unretired write replaces it and flags the overrun.
                    if (state_q != ST_IDLE) begin
                        err_d[1] = 1'b1;
                    end
                    addr_d = dst;
                    if (wb_sel == WB_MEM) begin
                        state_d = ST_WMEM;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = ST_READY;
                        data_d  = (wb_sel == WB_LINK) ? pc_link : alu_res;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end else if (phase[PH_M] && state_q == ST_WMEM) begin
                if (mem_valid) begin
                    data_d  = mem_rdata;
                    state_d = ST_READY;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        state_d  = ST_IDLE;
                        err_d[0] = 1'b1;
                    end
                end
            end else if (phase[PH_W]) begin
                if (state_q == ST_WMEM) begin
                    err_d[0] = 1'b1;
                end
                state_d = ST_IDLE;
            end
        end
    end

`ifdef R0_ZERO_EN
    assign wr_ok = (addr_q != '0);
`else
    assign wr_ok = 1'b1;
`endif

    always_comb begin
        stall = 1'b0;
        we    = 1'b0;
        if (phase_ok) begin
            stall = phase[PH_M] && (state_q == ST_WMEM) && !mem_valid;
            we    = phase[PH_W] && ((state_q == ST_READY) || (state_q == ST_PEND)) && wr_ok;
        end
    end

    assign wa  = addr_q;
    assign wd  = data_q;
    assign err = err_q;

endmodule
